dt_seq_eval: RTL and testbench
==============================

DT_SEQ_EVAL -- requirements
Module: dt_seq_eval

Interface
REQ-001 Parameter N_FEAT, 8, number of input features.
REQ-002 Parameter FEAT_W, 6, feature and threshold width (unsigned).
REQ-003 Parameter N_NODES, 32, node-table depth; root is address 0.
REQ-004 Parameter CLASS_W, 5, class label width; SHALL satisfy CLASS_W <= FEAT_W.
REQ-005 Parameter DEPTH_MAX, 16, maximum nodes visited per inference.
REQ-006 Design SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_valid / in_ready  in / out  1 / 1  feature-vector handshake.
REQ-010 in_feat  in  N_FEAT*FEAT_W  packed features, feature i at bits [i*FEAT_W +: FEAT_W].
REQ-011 cfg_we, cfg_addr, cfg_data  in  1, clog2(N_NODES), NODE_W  node-table write port.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_class  out  CLASS_W  predicted class; out_err  out  1  depth-limit or bad-index error.

Function
REQ-014 Node word SHALL be {is_leaf, feat_idx[clog2(N_FEAT)], thr[FEAT_W], left[clog2(N_NODES)], right[clog2(N_NODES)]}; leaf class = thr[CLASS_W-1:0].
REQ-015 FSM states IDLE, WALK, DONE; IDLE->WALK on in_valid&&in_ready, WALK->DONE on leaf or error, DONE->IDLE on out_valid&&out_ready.
REQ-016 in_ready SHALL be 1 only in IDLE; accepted in_feat SHALL be registered and held for the whole inference.
REQ-017 WALK SHALL visit exactly one node per cycle, starting at address 0.
REQ-018 Internal node: next = left if feat[feat_idx] <= thr (unsigned), else right.
REQ-019 Leaf: out_class <= leaf class, out_err <= 0, enter DONE next cycle.
REQ-020 Latency: out_valid asserts k+1 cycles after acceptance, k = nodes visited including leaf.
REQ-021 If the DEPTH_MAX-th visited node is not a leaf, or feat_idx >= N_FEAT, SHALL enter DONE with out_class=0, out_err=1.
REQ-022 out_valid=1 only in DONE; out_class/out_err SHALL hold stable while out_valid && !out_ready.
REQ-023 cfg_we SHALL write the node table only in IDLE; writes in WALK or DONE SHALL be dropped.
REQ-024 cfg_we in the same cycle as an accepted input: the write SHALL complete and the inference SHALL see the new node contents.

Reset
REQ-025 rst_n low SHALL force IDLE, in_ready=0 during reset then 1, out_valid=0, out_class=0, out_err=0, mid-inference work discarded.
REQ-026 Node table contents SHALL NOT be reset; they are undefined until written.

Configuration
REQ-027 Macro DT_PERF_CNT_EN: when defined, port perf_cnt (out, 16) SHALL count completed output handshakes, saturating at 16'hFFFF, reset to 0.
REQ-028 Without DT_PERF_CNT_EN the perf_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package dt_pkg SHALL hold the FSM state enum, node-word field widths/offsets, and a node-word struct typedef.
REQ-030 Sub-module dt_node_ram (N_NODES x NODE_W, one write port, one asynchronous read port) SHALL hold the node table.

Verification
REQ-031 Table: node0 {feat2<=10 ? 1 : 2}, node1 leaf 3, node2 leaf 7; feat2=10 -> out_class=3, out_err=0, out_valid 3 cycles after accept.
REQ-032 Same table, feat2=11 -> out_class=7; feat2=63 -> out_class=7.
REQ-033 Node0 left=0 (self-loop, non-leaf), DEPTH_MAX=16 -> out_err=1, out_class=0 after 17 cycles.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_class stable, in_ready=0, new in_valid ignored; cfg_we during WALK leaves table unchanged.
REQ-035 rst_n pulsed low in WALK -> out_valid=0 immediately, IDLE, next inference correct.
REQ-036 With DT_PERF_CNT_EN, 3 completed inferences -> perf_cnt=3; preset near max -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/dt_pkg.sv
// dt_pkg: shared FSM state type, node-word layout and node-word struct for the
// sequential decision-tree evaluator. Layout constants describe the default
// configuration (8 features of 6 bits, 32 nodes); the top recomputes the same
// layout from its own parameters.
package dt_pkg;

  localparam int unsigned DT_N_FEAT  = 8;
  localparam int unsigned DT_FEAT_W  = 6;
  localparam int unsigned DT_N_NODES = 32;
  localparam int unsigned DT_CLASS_W = 5;

  // Field widths
  localparam int unsigned DT_FIDX_W = $clog2(DT_N_FEAT);
  localparam int unsigned DT_ADDR_W = $clog2(DT_N_NODES);

  // Field offsets, LSB first: right, left, thr, feat_idx, is_leaf
  localparam int unsigned DT_RIGHT_OFF = 0;
  localparam int unsigned DT_LEFT_OFF  = DT_RIGHT_OFF + DT_ADDR_W;
  localparam int unsigned DT_THR_OFF   = DT_LEFT_OFF + DT_ADDR_W;
  localparam int unsigned DT_FIDX_OFF  = DT_THR_OFF + DT_FEAT_W;
  localparam int unsigned DT_LEAF_OFF  = DT_FIDX_OFF + DT_FIDX_W;
  localparam int unsigned DT_NODE_W    = DT_LEAF_OFF + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StDone
  } dt_state_e;

  // Bit-for-bit image of a node word in the default configuration
  typedef struct packed {
    logic                 is_leaf;
    logic [DT_FIDX_W-1:0] feat_idx;
    logic [DT_FEAT_W-1:0] thr;
    logic [DT_ADDR_W-1:0] left;
    logic [DT_ADDR_W-1:0] right;
  } dt_node_t;

  // Node-word width for an arbitrary configuration
  function automatic int unsigned node_width(input int unsigned n_feat,
                                             input int unsigned feat_w,
                                             input int unsigned n_nodes);
    return 1 + $clog2(n_feat) + feat_w + 2 * $clog2(n_nodes);
  endfunction

endpackage

// File: rtl/dt_node_ram.sv
// dt_node_ram: node table, one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset.
module dt_node_ram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 20,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dt_seq_eval.sv
// dt_seq_eval: walks a decision tree stored in a node table, one node per
// cycle, from the root at address 0 until a leaf, a bad feature index or the
// depth limit ends the inference.
// Build option: define DT_PERF_CNT_EN to add perf_cnt, a saturating 16-bit
// count of completed result handshakes.
module dt_seq_eval
  import dt_pkg::*;
#(
  parameter int unsigned N_FEAT    = 8,
  parameter int unsigned FEAT_W    = 6,
  parameter int unsigned N_NODES   = 32,
  parameter int unsigned CLASS_W   = 5,
  parameter int unsigned DEPTH_MAX = 16,
  localparam int unsigned FIDX_W   = $clog2(N_FEAT),
  localparam int unsigned ADDR_W   = $clog2(N_NODES),
  localparam int unsigned NODE_W   = node_width(N_FEAT, FEAT_W, N_NODES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
`ifdef DT_PERF_CNT_EN
  ,
  output logic [15:0]              perf_cnt
`endif
);

  // Node-word layout for this configuration
  localparam int unsigned RIGHT_OFF = 0;
  localparam int unsigned LEFT_OFF  = RIGHT_OFF + ADDR_W;
  localparam int unsigned THR_OFF   = LEFT_OFF + ADDR_W;
  localparam int unsigned FIDX_OFF  = THR_OFF + FEAT_W;
  localparam int unsigned LEAF_OFF  = FIDX_OFF + FIDX_W;
  localparam int unsigned DCNT_W    = $clog2(DEPTH_MAX + 1);

  dt_state_e                state_q, state_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DCNT_W-1:0]        depth_q, depth_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic                     err_q, err_d;

  logic [NODE_W-1:0]        node_word;
  logic                     node_leaf;
  logic [FIDX_W-1:0]        node_fidx;
  logic [FEAT_W-1:0]        node_thr;
  logic [ADDR_W-1:0]        node_left;
  logic [ADDR_W-1:0]        node_right;
  logic [FEAT_W-1:0]        feat_sel;
  logic                     fidx_bad;
  logic                     ram_we;
  logic                     accept;

  // Table writes only land while idle; a write coinciding with acceptance
  // completes on the same edge, so the walk that follows sees it.
  assign ram_we = cfg_we && (state_q == StIdle);

  dt_node_ram #(
    .DEPTH (N_NODES),
    .WIDTH (NODE_W)
  ) u_node_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (addr_q),
    .rdata (node_word)
  );

  assign node_leaf  = node_word[LEAF_OFF];
  assign node_fidx  = node_word[FIDX_OFF +: FIDX_W];
  assign node_thr   = node_word[THR_OFF +: FEAT_W];
  assign node_left  = node_word[LEFT_OFF +: ADDR_W];
  assign node_right = node_word[RIGHT_OFF +: ADDR_W];
  assign fidx_bad   = (int'(node_fidx) >= int'(N_FEAT));

  // Pick the feature addressed by the current node
  always_comb begin
    feat_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (node_fidx == FIDX_W'(i)) begin
        feat_sel = feat_q[i*FEAT_W +: FEAT_W];
      end
    end
  end

  // Reset gates in_ready so nothing is accepted while rst_n is low
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    addr_d  = addr_q;
    depth_d = depth_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWalk;
          feat_d  = in_feat;
          addr_d  = '0;
          depth_d = DCNT_W'(1);
        end
      end
      StWalk: begin
        if (node_leaf) begin
          class_d = node_thr[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (fidx_bad || (depth_q == DCNT_W'(DEPTH_MAX))) begin
          // Last allowed visit was not a leaf, or the node is malformed
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = (feat_sel <= node_thr) ? node_left : node_right;
          depth_d = depth_q + DCNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      feat_q  <= '0;
      addr_q  <= '0;
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      addr_q  <= addr_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

`ifdef DT_PERF_CNT_EN
  logic [15:0] perf_q;

  // Count completed result handshakes, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (out_valid && out_ready && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_dt_seq_eval.sv
// tb_dt_seq_eval: directed and randomized checks of dt_seq_eval against a
// behavioural tree-walk model.
module tb_dt_seq_eval;
  import dt_pkg::*;

  localparam int unsigned NF = DT_N_FEAT;
  localparam int unsigned FW = DT_FEAT_W;
  localparam int unsigned NN = DT_N_NODES;
  localparam int unsigned CW = DT_CLASS_W;
  localparam int unsigned DM = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [NF*FW-1:0]     in_feat = '0;
  logic                 cfg_we = 1'b0;
  logic [DT_ADDR_W-1:0] cfg_addr = '0;
  logic [DT_NODE_W-1:0] cfg_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CW-1:0]        out_class;
  logic                 out_err;
`ifdef DT_PERF_CNT_EN
  logic [15:0]          perf_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_hs   = 0;

  dt_node_t mdl [NN];

  dt_seq_eval #(
    .N_FEAT    (NF),
    .FEAT_W    (FW),
    .N_NODES   (NN),
    .CLASS_W   (CW),
    .DEPTH_MAX (DM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err)
`ifdef DT_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic dt_node_t mk(input bit leaf, input int fi, input int thr,
                                  input int l, input int r);
    dt_node_t n;
    n.is_leaf  = leaf;
    n.feat_idx = DT_FIDX_W'(fi);
    n.thr      = DT_FEAT_W'(thr);
    n.left     = DT_ADDR_W'(l);
    n.right    = DT_ADDR_W'(r);
    return n;
  endfunction

  // Random feature vector with feature 2 forced to v
  function automatic logic [NF*FW-1:0] feat2(input int v);
    logic [NF*FW-1:0] f;
    f = (NF*FW)'({$urandom(), $urandom()});
    f[2*FW +: FW] = FW'(v);
    return f;
  endfunction

  // Reference walk: follow the tree rules directly over the model table
  function automatic void mdl_eval(input logic [NF*FW-1:0] f, output int cls,
                                   output int err, output int k);
    int a;
    int fv;
    dt_node_t n;
    a = 0; cls = 0; err = 1; k = DM;
    for (int d = 1; d <= DM; d++) begin
      n = mdl[a];
      if (n.is_leaf) begin
        cls = int'(n.thr) % (1 << CW);
        err = 0;
        k = d;
        return;
      end
      if (int'(n.feat_idx) >= NF) begin
        k = d;
        return;
      end
      fv = int'((f >> (int'(n.feat_idx) * FW)) & 48'h3f);
      a = (fv <= int'(n.thr)) ? int'(n.left) : int'(n.right);
    end
  endfunction

  task automatic cfg_write(input int a, input dt_node_t n);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = DT_ADDR_W'(a); cfg_data = n;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mdl[a] = n;
  endtask

  // From just after the accepting edge: wait for the result, check it,
  // optionally stall and/or attempt a table write mid-walk, then handshake.
  task automatic finish_infer(input string tag, input int ecls, input int eerr, input int elat,
                              input int stall, input bit walk_wr,
                              output int cls, output int lat);
    logic [CW-1:0] held_c;
    logic          held_e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (walk_wr && lat == 1) begin
        cfg_we = 1'b1; cfg_addr = DT_ADDR_W'(1); cfg_data = mk(1, 0, 9, 0, 0);
      end
      if (lat == 2) cfg_we = 1'b0;
    end while (!out_valid && lat < 40);
    cfg_we = 1'b0;
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_class"}, 32'(out_class), ecls);
    check({tag, "_err"}, 32'(out_err), eerr);
    cls = int'(out_class);
    held_c = out_class;
    held_e = out_err;
    if (stall > 0) begin
      in_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        in_feat = feat2(int'($urandom_range(0, 63)));
        check({tag, "_hold_class"}, 32'(out_class), 32'(held_c));
        check({tag, "_hold_err"}, 32'(out_err), 32'(held_e));
        check({tag, "_hold_valid"}, 32'(out_valid), 1);
        check({tag, "_busy"}, 32'(in_ready), 0);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_hs++;
    check({tag, "_idle"}, 32'(in_ready), 1);
    check({tag, "_novalid"}, 32'(out_valid), 0);
  endtask

  task automatic infer(input string tag, input logic [NF*FW-1:0] f, input int stall,
                       output int cls, output int lat);
    int ecls, eerr, ek, w;
    mdl_eval(f, ecls, eerr, ek);
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1; in_feat = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_infer(tag, ecls, eerr, ek + 1, stall, 1'b0, cls, lat);
  endtask

  initial begin
    int c, l;
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_class", 32'(out_class), 0);
    check("rst_out_err", 32'(out_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    for (int a = 0; a < NN; a++) cfg_write(a, mk(1, 0, a, 0, 0));

    // Basic split on feature 2
    cfg_write(0, mk(0, 2, 10, 1, 2));
    cfg_write(1, mk(1, 0, 3, 0, 0));
    cfg_write(2, mk(1, 0, 7, 0, 0));
    infer("eq_thr", feat2(10), 0, c, l);
    check("eq_thr_const_class", c, 3);
    check("eq_thr_const_lat", l, 3);
    infer("above_thr", feat2(11), 0, c, l);
    check("above_thr_const_class", c, 7);
    infer("max_feat", feat2(63), 0, c, l);
    check("max_feat_const_class", c, 7);
    infer("zero_feat", feat2(0), 0, c, l);
    check("zero_feat_const_class", c, 3);

    // Self-loop hits the depth limit
    cfg_write(0, mk(0, 2, 10, 0, 2));
    infer("depth_err", feat2(5), 0, c, l);
    check("depth_err_const_err", 32'(out_err), 1);
    check("depth_err_const_lat", l, DM + 1);

    // Back-pressure in DONE with inputs offered
    cfg_write(0, mk(0, 2, 10, 1, 2));
    infer("stall", feat2(10), 5, c, l);
    check("stall_const_class", c, 3);

    // Table write during the walk is dropped (model untouched)
    @(negedge clk);
    in_valid = 1'b1; in_feat = feat2(10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    finish_infer("walk_wr", 3, 0, 3, 0, 1'b1, c, l);
    infer("after_walk_wr", feat2(9), 0, c, l);
    check("after_walk_wr_const_class", c, 3);

    // Write coinciding with acceptance is seen by that inference
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = '0; cfg_data = mk(1, 0, 21, 0, 0);
    in_valid = 1'b1; in_feat = feat2(0);
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    mdl[0] = mk(1, 0, 21, 0, 0);
    finish_infer("same_cyc_wr", 21, 0, 2, 0, 1'b0, c, l);

    // Reset mid-walk
    cfg_write(0, mk(0, 2, 10, 0, 2));
    cfg_write(1, mk(1, 0, 3, 0, 0));
    infer("pre_rst", feat2(20), 0, c, l);
    @(negedge clk);
    in_valid = 1'b1; in_feat = feat2(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_out_class", 32'(out_class), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_hs = 0;
    #1;
    check("midrst_idle", 32'(in_ready), 1);
    repeat (20) @(negedge clk);
    check("midrst_no_result", 32'(out_valid), 0);
    cfg_write(0, mk(0, 2, 10, 1, 2));
    infer("post_rst", feat2(11), 0, c, l);
    check("post_rst_const_class", c, 7);

    // Randomized tables and features
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < NN; a++) begin
        cfg_write(a, mk(($urandom_range(0, 2) == 0) || (r >= 4 && $urandom_range(0, 1) == 0),
                        int'($urandom_range(0, NF - 1)), int'($urandom_range(0, 63)),
                        int'($urandom_range(0, NN - 1)), int'($urandom_range(0, NN - 1))));
      end
      for (int t = 0; t < 8; t++) begin
        infer("rand", (NF*FW)'({$urandom(), $urandom()}), int'($urandom_range(0, 2)), c, l);
      end
    end

`ifdef DT_PERF_CNT_EN
    check("perf_count", 32'(perf_cnt), n_hs);
    @(negedge clk);
    dut.perf_q = 16'hFFFD;
    for (int t = 0; t < 3; t++) infer("perf_sat_run", feat2(4), 0, c, l);
    check("perf_sat", 32'(perf_cnt), 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
